frame_mem_arbiter: RTL and testbench
====================================

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameter PIX_ADDR_W, default 19: pixel address width (640x480 = 307200 pixels).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive client denials before the client is forced through.
REQ-003 Ports: clk input 1 is the single clock; rst input 1 is the reset, asynchronous and active-high.
REQ-004 Port vga_en input 1: active-display qualifier; no VGA fetches while low.
REQ-005 Port vga_addr input PIX_ADDR_W: pixel address from the scan counter.
REQ-006 Ports o_red, o_green, o_blue output 8 each: pixel colour, 8'hFF if the pixel bit is 1, else 8'h00.
REQ-007 Port vga_underrun output 1: one-cycle pulse when a VGA fetch is displaced by a forced client access.
REQ-008 Ports cli_req input 1, cli_we input 1, cli_addr input PIX_ADDR_W-3, cli_wdata input 8: client byte request.
REQ-009 Ports cli_gnt output 1, cli_rvalid output 1, cli_rdata output 8: client accept, read-data valid and read data.
REQ-010 Ports ram_addr output PIX_ADDR_W-3, ram_we output 1, ram_wdata output 8, ram_rdata input 8: single-port synchronous frame RAM with 1-cycle read latency.

Function
REQ-011 byte_addr = vga_addr[PIX_ADDR_W-1:3]; bit select = 7 - vga_addr[2:0], so the pixel with offset 0 is the MSB.
REQ-012 vga_need = vga_en AND (held byte invalid OR byte_addr differs from held_addr).
REQ-013 FSM states: IDLE, VGA_RD, CLI_RD, CLI_WR; each RAM access occupies exactly one cycle, and a new access may issue every cycle.
REQ-014 Winner per cycle: VGA if vga_need and the starvation count is below STARVE_LIMIT; otherwise the client if cli_req is high; otherwise IDLE.
REQ-015 ram_addr, ram_we and ram_wdata are combinational from the winner; ram_we is high only in CLI_WR.
REQ-016 cli_gnt is high in the same cycle the client wins; the client holds req, we, addr and wdata stable until it sees gnt.
REQ-017 Client read: cli_rvalid pulses 1 cycle after gnt, and cli_rdata equals ram_rdata in that cycle; cli_rdata is held otherwise.
REQ-018 VGA fetch: RAM data is captured into the held byte 1 cycle after issue, together with held_addr, and the byte is marked valid.
REQ-019 Pixel latency: o_red, o_green and o_blue reflect vga_addr exactly 2 cycles after it is presented, whether the access is a hit or a fetch; bit-select and vga_en are delayed to match.
REQ-020 If vga_en is low (delayed 2 cycles), the colour outputs are 8'h00.
REQ-021 The starvation counter increments on each cycle with cli_req high and no grant, clears on grant, and saturates at STARVE_LIMIT.
REQ-022 Forced client cycle (count == STARVE_LIMIT and vga_need): the client wins, vga_underrun pulses, and the affected pixel outputs 8'h00.
REQ-023 Coherency: a client write to held_addr updates the held byte in the same edge, so the next pixel sees the new data.
REQ-024 Simultaneous VGA fetch and client write to the same byte: VGA wins and the write follows next cycle; the held byte is then updated per REQ-023.
REQ-025 Address wrap from the last byte to 0 is handled as an ordinary byte change (fetch).

Reset
REQ-026 On rst: the FSM goes to IDLE and the held byte and held_addr are cleared and invalid.
REQ-027 On rst: the starvation counter is 0, all colour outputs are 8'h00, and cli_gnt, cli_rvalid, vga_underrun and ram_we are 0.
REQ-028 A read in flight at reset produces no cli_rvalid after reset release.

Structure
REQ-029 A shared package holds the FSM state encoding, the 640x480 frame constants and BYTE_ADDR_W = PIX_ADDR_W-3.
REQ-030 One sub-module, pix_unpack, holds the held byte, its coherency update and the 2-stage bit-select and colour pipeline.

Verification
REQ-031 vga_en=1, vga_addr stepping 0..15 with RAM[0]=8'hA5 and RAM[1]=8'h0F -> exactly 2 fetches; colours FF,00,FF,00,00,FF,00,FF,00,00,00,00,FF,FF,FF,FF starting 2 cycles later.
REQ-032 Client read of addr 16'h0010 (RAM=8'h3C) while vga_en=0 -> gnt in the same cycle, then rvalid=1 with rdata=8'h3C the next cycle.
REQ-033 vga_addr changes byte every cycle with cli_req held high -> gnt on the 5th request cycle, vga_underrun pulses once, and that pixel is 00.
REQ-034 Held byte 8'h00 at addr 5, client writes 8'hFF to addr 5 -> the following pixels of byte 5 are FF with no refetch.
REQ-035 rst asserted during CLI_RD -> all outputs 0 immediately and no rvalid after release.
REQ-036 vga_addr wraps from 307199 to 0 -> a refetch of byte 0 occurs and the 2-cycle latency is preserved.

Source files
------------

// File: rtl/frame_mem_arbiter_pkg.sv
// rtl/frame_mem_arbiter_pkg.sv - shared FSM encoding, frame constants and pixel colour helper
package frame_mem_arbiter_pkg;

  localparam int H_ACTIVE         = 640;
  localparam int V_ACTIVE         = 480;
  localparam int FRAME_PIXELS     = H_ACTIVE * V_ACTIVE;
  localparam int FRAME_PIX_ADDR_W = 19;
  localparam int BYTE_ADDR_W      = FRAME_PIX_ADDR_W - 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VGA_RD,
    ST_CLI_RD,
    ST_CLI_WR
  } arb_state_t;

  function automatic logic [7:0] pix_colour(input logic bit_val);
    return bit_val ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_pix_unpack.sv
// rtl/frame_mem_arbiter_pix_unpack.sv - held display byte with write coherency and
// the two-stage bit-select / colour pipeline
module pix_unpack
  import frame_mem_arbiter_pkg::*;
#(
  parameter int BW = BYTE_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cap,
  input  logic [BW-1:0] i_cap_addr,
  input  logic [7:0]    i_ram_rdata,
  input  logic          i_wr,
  input  logic [BW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_en,
  input  logic [2:0]    i_ofs,
  input  logic          i_fetch,
  input  logic          i_drop,
  output logic          o_held_valid,
  output logic [BW-1:0] o_held_addr,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue
);

  logic [7:0]    r_held_byte;
  logic          r_held_valid;
  logic [BW-1:0] r_held_addr;
  logic          r_en_d1;
  logic          r_fetch_d1;
  logic          r_drop_d1;
  logic [2:0]    r_bit_d1;
  logic [7:0]    r_colour;
  logic [7:0]    w_src_byte;
  logic          w_pix_bit;

  // A write landing on the byte being captured wins over the stale RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held_byte  <= 8'h00;
      r_held_valid <= 1'b0;
      r_held_addr  <= '0;
    end else if (i_cap) begin
      r_held_addr  <= i_cap_addr;
      r_held_valid <= 1'b1;
      r_held_byte  <= (i_wr && (i_wr_addr == i_cap_addr)) ? i_wr_data : i_ram_rdata;
    end else if (i_wr && r_held_valid && (i_wr_addr == r_held_addr)) begin
      r_held_byte  <= i_wr_data;
    end
  end

  // A fetched pixel takes its byte straight off the RAM bus; a hit uses the held byte.
  assign w_src_byte = r_fetch_d1 ? i_ram_rdata : r_held_byte;
  assign w_pix_bit  = w_src_byte[r_bit_d1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d1    <= 1'b0;
      r_fetch_d1 <= 1'b0;
      r_drop_d1  <= 1'b0;
      r_bit_d1   <= 3'd0;
      r_colour   <= 8'h00;
    end else begin
      r_en_d1    <= i_en;
      r_fetch_d1 <= i_fetch;
      r_drop_d1  <= i_drop;
      r_bit_d1   <= 3'd7 - i_ofs;
      r_colour   <= (r_en_d1 && !r_drop_d1) ? pix_colour(w_pix_bit) : 8'h00;
    end
  end

  assign o_held_valid = r_held_valid;
  assign o_held_addr  = r_held_addr;
  assign o_red        = r_colour;
  assign o_green      = r_colour;
  assign o_blue       = r_colour;

endmodule

// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - single-port frame RAM arbiter between VGA scan-out and a
// byte client, with starvation forcing
module frame_mem_arbiter
  import frame_mem_arbiter_pkg::*;
#(
  parameter int PIX_ADDR_W   = FRAME_PIX_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vga_en,
  input  logic [PIX_ADDR_W-1:0] vga_addr,
  output logic [7:0]            o_red,
  output logic [7:0]            o_green,
  output logic [7:0]            o_blue,
  output logic                  vga_underrun,
  input  logic                  cli_req,
  input  logic                  cli_we,
  input  logic [PIX_ADDR_W-4:0] cli_addr,
  input  logic [7:0]            cli_wdata,
  output logic                  cli_gnt,
  output logic                  cli_rvalid,
  output logic [7:0]            cli_rdata,
  output logic [PIX_ADDR_W-4:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  localparam int BW = PIX_ADDR_W - 3;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [CW-1:0] r_starve;
  logic [BW-1:0] r_fetch_addr;
  logic [7:0]    r_rdata;
  logic [BW-1:0] w_byte_addr;
  logic [BW-1:0] w_held_addr;
  logic          w_held_valid;
  logic          w_tag_valid;
  logic [BW-1:0] w_tag_addr;
  logic          w_vga_need;
  logic          w_forced;

  assign w_byte_addr = vga_addr[PIX_ADDR_W-1:3];

  // A fetch still in flight already owns the byte, so it shadows the held tag.
  assign w_tag_valid = (r_state == ST_VGA_RD) || w_held_valid;
  assign w_tag_addr  = (r_state == ST_VGA_RD) ? r_fetch_addr : w_held_addr;
  assign w_vga_need  = vga_en && !(w_tag_valid && (w_tag_addr == w_byte_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve     <= '0;
      r_fetch_addr <= '0;
      r_rdata      <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_VGA_RD) r_fetch_addr <= w_byte_addr;
      if (r_state == ST_CLI_RD) r_rdata <= ram_rdata;
      if (cli_gnt) r_starve <= '0;
      else if (cli_req && (r_starve < LIM)) r_starve <= r_starve + 1'b1;
    end
  end

  // The winner issues its RAM access combinationally in the same cycle.
  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_forced     = 1'b0;
    cli_gnt      = 1'b0;
    vga_underrun = 1'b0;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = 8'h00;
    if (!rst) begin
      if (w_vga_need && ((r_starve < LIM) || !cli_req)) begin
        w_state_nxt = ST_VGA_RD;
        ram_addr    = w_byte_addr;
      end else if (cli_req) begin
        w_state_nxt  = cli_we ? ST_CLI_WR : ST_CLI_RD;
        w_forced     = w_vga_need;
        cli_gnt      = 1'b1;
        vga_underrun = w_vga_need;
        ram_addr     = cli_addr;
        ram_we       = cli_we;
        ram_wdata    = cli_we ? cli_wdata : 8'h00;
      end
    end
  end

  assign cli_rvalid = (r_state == ST_CLI_RD);
  assign cli_rdata  = cli_rvalid ? ram_rdata : r_rdata;

  pix_unpack #(
    .BW(BW)
  ) u_pix_unpack (
    .clk          (clk),
    .rst          (rst),
    .i_cap        (r_state == ST_VGA_RD),
    .i_cap_addr   (r_fetch_addr),
    .i_ram_rdata  (ram_rdata),
    .i_wr         (w_state_nxt == ST_CLI_WR),
    .i_wr_addr    (cli_addr),
    .i_wr_data    (cli_wdata),
    .i_en         (vga_en),
    .i_ofs        (vga_addr[2:0]),
    .i_fetch      (w_state_nxt == ST_VGA_RD),
    .i_drop       (w_forced),
    .o_held_valid (w_held_valid),
    .o_held_addr  (w_held_addr),
    .o_red        (o_red),
    .o_green      (o_green),
    .o_blue       (o_blue)
  );

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb/tb_frame_mem_arbiter.sv - directed and randomized bench for frame_mem_arbiter
module tb_frame_mem_arbiter;
  import frame_mem_arbiter_pkg::*;

  localparam int PW  = 19;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_en;
  logic [18:0] vga_addr;
  logic [7:0]  o_red, o_green, o_blue;
  logic        vga_underrun;
  logic        cli_req, cli_we;
  logic [15:0] cli_addr;
  logic [7:0]  cli_wdata;
  logic        cli_gnt, cli_rvalid;
  logic [7:0]  cli_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  frame_mem_arbiter #(.PIX_ADDR_W(PW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .vga_en(vga_en), .vga_addr(vga_addr),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .vga_underrun(vga_underrun),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_gnt(cli_gnt), .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference model: memory image, last byte the display fetched, starvation count.
  logic [7:0] mdl_mem [0:65535];
  bit         m_have;
  int         m_tag;
  int         m_cnt;
  logic [7:0] col_d1, col_d2;
  bit         rv_q;
  logic [7:0] rd_q;
  bit         last_gnt;
  int         total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_cnt = 0; col_d1 = 8'h00; col_d2 = 8'h00; rv_q = 0; rd_q = 8'h00;
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = 16'(a); pre_data = d; mdl_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_cycle();
    int byte_i, ofs;
    bit need, vga_w, cli_w, forced;
    logic [7:0] col;
    @(negedge clk);
    byte_i = int'(vga_addr >> 3);
    ofs    = int'(vga_addr[2:0]);
    need   = vga_en && !(m_have && (m_tag == byte_i));
    vga_w  = need && ((m_cnt < LIM) || !cli_req);
    cli_w  = cli_req && !vga_w;
    forced = cli_w && need;
    chk("gnt", 32'(cli_gnt), 32'(cli_w));
    chk("underrun", 32'(vga_underrun), 32'(forced));
    chk("ram_we", 32'(ram_we), 32'(cli_w && cli_we));
    if (vga_w) chk("ram_addr_vga", 32'(ram_addr), 32'(byte_i));
    if (cli_w) chk("ram_addr_cli", 32'(ram_addr), 32'(cli_addr));
    if (cli_w && cli_we) chk("ram_wdata", 32'(ram_wdata), 32'(cli_wdata));
    chk("rvalid", 32'(cli_rvalid), 32'(rv_q));
    if (rv_q) chk("rdata", 32'(cli_rdata), 32'(rd_q));
    chk("red", 32'(o_red), 32'(col_d2));
    chk("green", 32'(o_green), 32'(col_d2));
    chk("blue", 32'(o_blue), 32'(col_d2));
    if (vga_w) begin m_have = 1; m_tag = byte_i; end
    if (cli_w && cli_we) mdl_mem[cli_addr] = cli_wdata;
    rv_q = cli_w && !cli_we;
    rd_q = rv_q ? mdl_mem[cli_addr] : 8'h00;
    col  = 8'h00;
    if (vga_en && !forced && mdl_mem[byte_i][7-ofs]) col = 8'hFF;
    col_d2 = col_d1;
    col_d1 = col;
    if (cli_w) m_cnt = 0;
    else if (cli_req && (m_cnt < LIM)) m_cnt++;
    last_gnt = cli_w;
    @(posedge clk); #1;
  endtask

  initial begin
    int v, step;
    total = 0; bad = 0; last_gnt = 0;
    rst = 1'b1; vga_en = 1'b1; vga_addr = '0;
    cli_req = 1'b1; cli_we = 1'b1; cli_addr = 16'h0003; cli_wdata = 8'h55;
    model_reset();
    #2;
    for (int i = 0; i <= 16; i++) begin
      if (i == 0) preload(i, 8'hA5);
      else if (i == 1) preload(i, 8'h0F);
      else if (i == 5) preload(i, 8'h00);
      else if (i == 16) preload(i, 8'h3C);
      else preload(i, 8'($urandom));
    end
    preload(FRAME_PIXELS / 8 - 1, 8'h5A);

    // reset state with a live request on the client port
    @(negedge clk);
    chk("rst_gnt", 32'(cli_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_rvalid", 32'(cli_rvalid), 0);
    chk("rst_underrun", 32'(vga_underrun), 0);
    chk("rst_colour", {8'h00, o_red, o_green, o_blue}, 0);
    @(posedge clk); #1;
    rst = 1'b0; cli_req = 1'b0;
    model_reset();

    // sixteen pixels across bytes 0 and 1
    vga_en = 1'b1;
    for (int i = 0; i < 16; i++) begin vga_addr = 19'(i); run_cycle(); end
    vga_en = 1'b0;
    run_cycle(); run_cycle();

    // client read while the display is idle
    cli_req = 1'b1; cli_we = 1'b0; cli_addr = 16'h0010;
    run_cycle();
    cli_req = 1'b0;
    run_cycle(); run_cycle();
    chk("rdata_hold", 32'(cli_rdata), 32'h3C);

    // byte changes every cycle: starvation forcing
    vga_en = 1'b1; cli_req = 1'b1; cli_we = 1'b0; cli_addr = 16'h0002;
    for (int i = 0; i < 8; i++) begin
      vga_addr = 19'(i * 8);
      run_cycle();
      if (last_gnt) cli_req = 1'b0;
    end

    // write into the held byte
    vga_addr = 19'd40; run_cycle();
    vga_addr = 19'd41; run_cycle();
    cli_req = 1'b1; cli_we = 1'b1; cli_addr = 16'h0005; cli_wdata = 8'hFF;
    vga_addr = 19'd42; run_cycle();
    cli_req = 1'b0;
    for (int i = 43; i < 48; i++) begin vga_addr = 19'(i); run_cycle(); end
    vga_en = 1'b0;
    run_cycle(); run_cycle();

    // reset while a client read is in flight
    cli_req = 1'b1; cli_we = 1'b0; cli_addr = 16'h0003;
    run_cycle();
    cli_req = 1'b0;
    rst = 1'b1; #1;
    chk("rst_mid_rvalid", 32'(cli_rvalid), 0);
    chk("rst_mid_gnt", 32'(cli_gnt), 0);
    chk("rst_mid_ram", {15'd0, ram_we, ram_addr}, 0);
    chk("rst_mid_colour", {8'h00, o_red, o_green, o_blue}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) run_cycle();

    // address wrap from the last pixel back to byte 0
    vga_en = 1'b1;
    for (int i = 0; i < 4; i++) begin vga_addr = 19'(i); run_cycle(); end
    for (int i = FRAME_PIXELS - 8; i < FRAME_PIXELS; i++) begin vga_addr = 19'(i); run_cycle(); end
    for (int i = 0; i < 8; i++) begin vga_addr = 19'(i); run_cycle(); end

    // randomized traffic on a small address window
    v = 0; step = 1;
    for (int c = 0; c < 1500; c++) begin
      if ((c % 32) == 0) step = ($urandom_range(0, 1) == 0) ? 1 : 8;
      if ($urandom_range(0, 15) == 0) v = $urandom_range(0, 127);
      else v = (v + step) % 128;
      vga_addr = 19'(v);
      vga_en = ($urandom_range(0, 7) != 0);
      if (!cli_req && ($urandom_range(0, 2) == 0)) begin
        cli_req   = 1'b1;
        cli_we    = 1'($urandom_range(0, 1));
        cli_addr  = 16'($urandom_range(0, 16));
        cli_wdata = 8'($urandom);
      end
      run_cycle();
      if (last_gnt) cli_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
